// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, reset PC, NOP encoding and the
// fetch-stage state enum.
package cpu_pkg;

  // Instruction address width (bit 15 of the CPU space selects peripherals,
  // so instruction memory is addressed with the low 15 bits only).
  localparam int ADDR_W = 15;

  // Instruction word width.
  localparam int DATA_W = 16;

  // Program counter value after reset.
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  // All-zero encoding is the NOP; also used as the instruction register's
  // cleared value.
  localparam logic [DATA_W-1:0] NOP = '0;

  // Fetch stage states.
  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_VALID   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues reads to the synchronous block memory,
// captures the returned word and offers it to the controller.
//
// Handshake: instr_valid is high while instr/instr_pc hold an unconsumed
// instruction; the word is consumed on any rising edge where instr_valid and
// instr_ready are both high. instr_valid never drops except through that
// accept, a redirect, or reset. While not accepted, instr and instr_pc are
// held stable.
module instruction_fetch #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        state_dbg
);

  import cpu_pkg::fetch_state_e;
  import cpu_pkg::ST_ISSUE;
  import cpu_pkg::ST_CAPTURE;
  import cpu_pkg::ST_VALID;
  import cpu_pkg::NOP;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              capture_en;
  logic              valid_d;

  // Next-state, next-PC and capture decision; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    capture_en = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (fetch_en) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // The read is already in flight, so this completes even if
        // fetch_en has since dropped. PC wraps naturally at 2^ADDR_W.
        state_d    = ST_VALID;
        pc_d       = pc_q + 1'b1;
        capture_en = 1'b1;
      end
      ST_VALID: begin
        if (instr_ready) begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
    if (redirect) begin
      // Drop any in-flight word, keep the old instr/instr_pc contents and
      // restart at the new target. A VALID word with instr_ready high is
      // still counted as consumed by the controller on this edge.
      state_d    = ST_ISSUE;
      pc_d       = redirect_pc;
      capture_en = 1'b0;
    end
  end

  assign valid_d = (state_d == ST_VALID);

  // FSM state, PC and registered valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ISSUE;
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_valid <= valid_d;
    end
  end

  // Instruction register: loads the memory word and its address on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= NOP;
      instr_pc <= '0;
    end else if (capture_en) begin
      instr    <= mem_data;
      instr_pc <= pc_q;
    end
  end

  // Memory address comes straight from the PC register; the read strobe is
  // decoded from the state and is held off while reset is asserted.
  assign mem_addr  = pc_q;
  assign mem_re    = reset && fetch_en && (state_q == ST_ISSUE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenario tasks followed by a
// randomized run checked against a transaction-level fetch model.
module tb_instruction_fetch;

  localparam int AW = 15;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          fetch_en;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .state_dbg   (state_dbg)
  );

  // Synchronous-read instruction memory: data appears the cycle after mem_re.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_re) mem_data <= mem[mem_addr];
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      settle();
      checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re got %0b want 0", mem_re); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
      checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %0h want 0", instr); end
      checks++; if (instr_pc !== 15'h0) begin errors++; $display("FAIL reset_instr_pc got %0h want 0", instr_pc); end
      checks++; if (mem_addr !== 15'h0) begin errors++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    end
  endtask

  task automatic test_basic_fetch();
    logic [DW-1:0] words [3];
    logic          exp_re, exp_v;
    int            k;
    words = '{16'h1234, 16'h5678, 16'h9ABC};
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cycle();
      settle();
      exp_re = (i % 3 == 0);
      exp_v  = (i % 3 == 2);
      k      = i / 3;
      checks++; if (mem_re !== exp_re) begin errors++; $display("FAIL basic_mem_re cyc %0d got %0b want %0b", i, mem_re, exp_re); end
      if (exp_re) begin
        checks++; if (mem_addr !== AW'(k)) begin errors++; $display("FAIL basic_mem_addr cyc %0d got %0h want %0h", i, mem_addr, k); end
      end
      checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL basic_valid cyc %0d got %0b want %0b", i, instr_valid, exp_v); end
      if (exp_v) begin
        checks++; if (instr !== words[k]) begin errors++; $display("FAIL basic_instr cyc %0d got %0h want %0h", i, instr, words[k]); end
        checks++; if (instr_pc !== AW'(k)) begin errors++; $display("FAIL basic_instr_pc cyc %0d got %0h want %0h", i, instr_pc, k); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      instr_ready = (i < 5 || i > 9);
      settle();
      if (i >= 5 && i <= 10) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %0b want 1", i, instr_valid); end
        checks++; if (instr !== 16'h5678) begin errors++; $display("FAIL stall_instr cyc %0d got %0h want 5678", i, instr); end
        checks++; if (instr_pc !== 15'h1) begin errors++; $display("FAIL stall_instr_pc cyc %0d got %0h want 1", i, instr_pc); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL stall_mem_re cyc %0d got %0b want 0", i, mem_re); end
      end
      if (i == 11) begin
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL stall_resume_re got %0b want 1", mem_re); end
        checks++; if (mem_addr !== 15'h2) begin errors++; $display("FAIL stall_resume_addr got %0h want 2", mem_addr); end
      end
    end
  endtask

  task automatic test_redirect_capture();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_pc = 15'h0040;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) next_cycle();
      redirect = (i == 10);
      settle();
      if (i == 9) begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h3) begin errors++; $display("FAIL rdc_issue3 got re=%0b addr=%0h want re=1 addr=3", mem_re, mem_addr); end
      end
      if (i == 11) begin
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rdc_re got %0b want 1", mem_re); end
        checks++; if (mem_addr !== 15'h0040) begin errors++; $display("FAIL rdc_addr got %0h want 40", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdc_valid_low got %0b want 0", instr_valid); end
        checks++; if (instr !== mem[2] || instr_pc !== 15'h2) begin errors++; $display("FAIL rdc_instr_hold got %0h@%0h want %0h@2", instr, instr_pc, mem[2]); end
      end
      if (i == 13) begin
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rdc_valid got %0b want 1", instr_valid); end
        checks++; if (instr !== mem[15'h40]) begin errors++; $display("FAIL rdc_instr got %0h want %0h", instr, mem[15'h40]); end
        checks++; if (instr_pc !== 15'h0040) begin errors++; $display("FAIL rdc_instr_pc got %0h want 40", instr_pc); end
      end
      if (i == 14) begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h0041) begin errors++; $display("FAIL rdc_next got re=%0b addr=%0h want re=1 addr=41", mem_re, mem_addr); end
      end
      if (i >= 10) begin
        checks++; if (instr_valid === 1'b1 && instr_pc === 15'h3) begin errors++; $display("FAIL rdc_dropped_word cyc %0d got instr_pc=3 want never", i); end
      end
    end
  endtask

  task automatic test_redirect_valid_accept();
    int seen;
    seen = 0;
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_pc = 15'h0010;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      redirect = (i == 2);
      settle();
      if (instr_valid === 1'b1 && instr_pc === 15'h0) seen++;
      if (i == 2) begin
        checks++; if (instr_valid !== 1'b1 || instr !== mem[0]) begin errors++; $display("FAIL rva_valid got v=%0b %0h want v=1 %0h", instr_valid, instr, mem[0]); end
      end
      if (i == 3) begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h0010) begin errors++; $display("FAIL rva_next got re=%0b addr=%0h want re=1 addr=10", mem_re, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rva_valid_low got %0b want 0", instr_valid); end
      end
      if (i == 5) begin
        checks++; if (instr_valid !== 1'b1 || instr !== mem[15'h10] || instr_pc !== 15'h10) begin errors++; $display("FAIL rva_target got v=%0b %0h@%0h want v=1 %0h@10", instr_valid, instr, instr_pc, mem[15'h10]); end
      end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL rva_accept_once got %0d want 1", seen); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_pc = 15'h7FFF;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      redirect = (i == 0);
      settle();
      if (i == 1) begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h7FFF) begin errors++; $display("FAIL wrap_issue got re=%0b addr=%0h want re=1 addr=7fff", mem_re, mem_addr); end
      end
      if (i == 3) begin
        checks++; if (instr_valid !== 1'b1 || instr !== mem[15'h7FFF] || instr_pc !== 15'h7FFF) begin errors++; $display("FAIL wrap_instr got v=%0b %0h@%0h want v=1 %0h@7fff", instr_valid, instr, instr_pc, mem[15'h7FFF]); end
      end
      if (i == 4) begin
        checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h0) begin errors++; $display("FAIL wrap_next_addr got re=%0b addr=%0h want re=1 addr=0", mem_re, mem_addr); end
      end
      if (i == 6) begin
        checks++; if (instr_valid !== 1'b1 || instr !== mem[0] || instr_pc !== 15'h0) begin errors++; $display("FAIL wrap_after got v=%0b %0h@%0h want v=1 %0h@0", instr_valid, instr, instr_pc, mem[0]); end
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    fetch_en = 1'b1; instr_ready = 1'b1; redirect_pc = 15'h0020;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) next_cycle();
      redirect = (i == 0);
      settle();
      if (i == 3) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0020) begin errors++; $display("FAIL rmc_pre_valid got v=%0b pc=%0h want v=1 pc=20", instr_valid, instr_pc); end
      end
    end
    // Cycle 5 is the capture of address 0x21; assert reset mid-cycle.
    reset = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmc_valid got %0b want 0", instr_valid); end
    checks++; if (mem_addr !== 15'h0) begin errors++; $display("FAIL rmc_pc got %0h want 0", mem_addr); end
    checks++; if (instr !== 16'h0 || instr_pc !== 15'h0) begin errors++; $display("FAIL rmc_instr got %0h@%0h want 0@0", instr, instr_pc); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL rmc_mem_re got %0b want 0", mem_re); end
    fetch_en = 1'b0;
    next_cycle();
    settle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      checks++; if (mem_re !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmc_frozen cyc %0d got re=%0b v=%0b want re=0 v=0", i, mem_re, instr_valid); end
    end
    next_cycle();
    fetch_en = 1'b1;
    settle();
    checks++; if (mem_re !== 1'b1 || mem_addr !== 15'h0) begin errors++; $display("FAIL rmc_first_re got re=%0b addr=%0h want re=1 addr=0", mem_re, mem_addr); end
    next_cycle();
    next_cycle();
    settle();
    checks++; if (instr_valid !== 1'b1 || instr !== mem[0] || instr_pc !== 15'h0) begin errors++; $display("FAIL rmc_first_instr got v=%0b %0h@%0h want v=1 %0h@0", instr_valid, instr, instr_pc, mem[0]); end
  endtask

  // Randomized run against a transaction-level model: a fetch is either
  // idle, has one read outstanding, or holds a delivered word.
  task automatic test_random();
    logic [AW-1:0] m_pc;
    logic          m_inflight;
    logic          m_valid;
    logic [DW-1:0] m_instr;
    logic [AW-1:0] m_ipc;
    logic          exp_re;
    do_reset();
    m_pc = '0; m_inflight = 1'b0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
    for (int i = 0; i < 500; i++) begin
      if (i > 0) next_cycle();
      fetch_en    = ($urandom_range(0, 3) != 0);
      instr_ready = $urandom_range(0, 1) == 1;
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'($urandom_range(32764, 32767));
      settle();
      exp_re = fetch_en && !m_valid && !m_inflight;
      checks++; if (mem_re !== exp_re) begin errors++; $display("FAIL rnd_mem_re cyc %0d got %0b want %0b", i, mem_re, exp_re); end
      if (exp_re) begin
        checks++; if (mem_addr !== m_pc) begin errors++; $display("FAIL rnd_mem_addr cyc %0d got %0h want %0h", i, mem_addr, m_pc); end
      end
      checks++; if (instr_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, instr_valid, m_valid); end
      checks++; if (instr !== m_instr || instr_pc !== m_ipc) begin errors++; $display("FAIL rnd_instr cyc %0d got %0h@%0h want %0h@%0h", i, instr, instr_pc, m_instr, m_ipc); end
      if (redirect) begin
        m_valid = 1'b0; m_inflight = 1'b0; m_pc = redirect_pc;
      end else if (m_valid) begin
        if (instr_ready) m_valid = 1'b0;
      end else if (m_inflight) begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 1'b1;
        m_valid = 1'b1; m_inflight = 1'b0;
      end else if (fetch_en) begin
        m_inflight = 1'b1;
      end
    end
    redirect = 1'b0;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_capture();
    test_redirect_valid_accept();
    test_wrap();
    test_reset_mid_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
